// File: rtl/dcm_prog_ctrl.sv
// ---------------------------------------------------------------------------
// dcm_prog_ctrl
//
// Master side of the dcm programming interface. It accepts a mode-change
// request over a valid/ready handshake, drives the mode onto prog_in, strobes
// update for one cycle, and waits for the dcm to echo the mode back on
// prog_out. If no echo arrives in time, the update is re-issued up to
// MAX_RETRY extra times. After that the controller gives up and pulses err.
// The last mode the dcm confirmed is kept on cur_mode.
//
// Parameters
//   MODE_W          width of the mode / prog bus
//   TIMEOUT_CYCLES  WAIT cycles without an echo before a retry (>= 2)
//   MAX_RETRY       re-issues allowed after the first attempt (0 = none)
//
// Ports
//   clk        in   system clock, everything on posedge
//   rst        in   synchronous reset, active-low
//   req_valid  in   request valid
//   req_mode   in   requested mode, sampled on accept
//   req_ready  out  high only while idle
//   prog_in    out  mode driven toward the dcm
//   update     out  one-cycle strobe toward the dcm
//   prog_out   in   echo from the dcm
//   done       out  one-cycle pulse: echo matched
//   err        out  one-cycle pulse: every attempt timed out
//   cur_mode   out  last confirmed mode
//   busy       out  inverse of req_ready
// ---------------------------------------------------------------------------
module dcm_prog_ctrl #(
   parameter int MODE_W         = 3,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [MODE_W-1:0] req_mode,
   output logic              req_ready,
   output logic [MODE_W-1:0] prog_in,
   output logic              update,
   input  logic [MODE_W-1:0] prog_out,
   output logic              done,
   output logic              err,
   output logic [MODE_W-1:0] cur_mode,
   output logic              busy
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [MODE_W-1:0] prog_in_q,   prog_in_d;
   logic [MODE_W-1:0] cur_mode_q,  cur_mode_d;
   logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
   logic [RTY_W-1:0]  retry_cnt_q, retry_cnt_d;
   logic              update_q,    update_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;
   logic              req_ready_q, req_ready_d;
   logic              busy_q,      busy_d;

   // Next-state logic. Every output is computed one cycle ahead here and
   // then registered, so update is high exactly while the FSM sits in DRIVE,
   // and done/err show up together with the return to IDLE.
   always_comb begin
      state_d     = state_q;
      prog_in_d   = prog_in_q;
      cur_mode_d  = cur_mode_q;
      tmo_cnt_d   = tmo_cnt_q;
      retry_cnt_d = retry_cnt_q;
      update_d    = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               prog_in_d   = req_mode;
               retry_cnt_d = '0;
               update_d    = 1'b1;
               state_d     = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            // Any echo seen in this cycle is stale, so it is not checked here.
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (prog_out == prog_in_q) begin
               done_d     = 1'b1;
               cur_mode_d = prog_in_q;
               state_d    = ST_IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               if (retry_cnt_q < RETRY_MAX) begin
                  retry_cnt_d = retry_cnt_q + RTY_W'(1);
                  update_d    = 1'b1;
                  state_d     = ST_DRIVE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
      busy_d      = ~req_ready_d;
   end

   // State and output registers. The reset clears everything, including any
   // transaction in flight. No done or err pulse is produced for a request
   // that a reset abandons.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         prog_in_q   <= '0;
         cur_mode_q  <= '0;
         tmo_cnt_q   <= '0;
         retry_cnt_q <= '0;
         update_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_in_q   <= prog_in_d;
         cur_mode_q  <= cur_mode_d;
         tmo_cnt_q   <= tmo_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         update_q    <= update_d;
         done_q      <= done_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign prog_in   = prog_in_q;
   assign update    = update_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cur_mode  = cur_mode_q;
   assign busy      = busy_q;

endmodule
